// File: rtl/fsm_seq_gen.sv
// Transmit side of the in1/in2 link: emits framed 10,00,10 symbol bursts
// that the companion sequence detector recognises once per frame.
module fsm_seq_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             in1_out,
  output logic             in2_out,
  output logic             sym_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  // Handshake: start is accepted only in IDLE and with abort low; busy goes
  // high one cycle later and stays high until the last symbol or an abort.
  // sym_valid qualifies in1/in2 as frame symbols; low means the 11 idle symbol.
  typedef enum logic [2:0] {IDLE, SYM0, SYM1, SYM2, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rep_q, rep_nxt, frame_cnt_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt, gap_cnt, gap_cnt_nxt;
  logic             done_nxt;
  logic             in1_nxt, in2_nxt, sym_valid_nxt, busy_nxt;
  logic             last_frame;

  assign last_frame = (frame_cnt + CNT_W'(1)) == rep_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
      in1_out   <= 1'b1;
      in2_out   <= 1'b1;
      sym_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rep_q     <= rep_nxt;
      gap_q     <= gap_nxt;
      gap_cnt   <= gap_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      done      <= done_nxt;
      in1_out   <= in1_nxt;
      in2_out   <= in2_nxt;
      sym_valid <= sym_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rep_nxt       = rep_q;
    gap_nxt       = gap_q;
    gap_cnt_nxt   = gap_cnt;
    frame_cnt_nxt = frame_cnt;
    done_nxt      = 1'b0;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            frame_cnt_nxt = '0;
            if (repeat_n != '0) begin
              rep_nxt   = repeat_n;
              gap_nxt   = gap;
              state_nxt = SYM0;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        SYM0: state_nxt = SYM1;
        SYM1: state_nxt = SYM2;
        SYM2: begin
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
          if (last_frame) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            // A zero gap still yields one idle symbol so the detector re-arms.
            state_nxt   = GAP;
            gap_cnt_nxt = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) state_nxt = SYM0;
          else               gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the wires change with the state.
  always_comb begin
    in1_nxt       = 1'b1;
    in2_nxt       = 1'b1;
    sym_valid_nxt = 1'b0;
    busy_nxt      = (state_nxt != IDLE);
    case (state_nxt)
      SYM0: begin in1_nxt = 1'b1; in2_nxt = 1'b0; sym_valid_nxt = 1'b1; end
      SYM1: begin in1_nxt = 1'b0; in2_nxt = 1'b0; sym_valid_nxt = 1'b1; end
      SYM2: begin in1_nxt = 1'b1; in2_nxt = 1'b0; sym_valid_nxt = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed bench for fsm_seq_gen with a model of the companion detector.
module tb_fsm_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] repeat_n = '0;
  logic [2:0] gap = '0;
  logic       in1_out, in2_out, sym_valid, busy, done;
  logic [3:0] frame_cnt;
  logic [8:0] obs;

  int errors = 0;
  int checks = 0;
  int det_st = 0;
  int det_hits = 0;
  int gap_hits = 0;

  fsm_seq_gen #(.CNT_W(4), .GAP_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .repeat_n(repeat_n), .gap(gap),
    .in1_out(in1_out), .in2_out(in2_out), .sym_valid(sym_valid),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // obs = {in1, in2, sym_valid, busy, done, frame_cnt}
  assign obs = {in1_out, in2_out, sym_valid, busy, done, frame_cnt};

  // Companion detector: 10 -> 00 -> 10 asserts out during the third symbol.
  always @(negedge clk) begin
    if (det_st == 2 && {in1_out, in2_out} == 2'b10) begin
      det_hits = det_hits + 1;
      if (!sym_valid) gap_hits = gap_hits + 1;
      det_st = 0;
    end else if ({in1_out, in2_out} == 2'b10) det_st = 1;
    else if (det_st == 1 && {in1_out, in2_out} == 2'b00) det_st = 2;
    else det_st = 0;
  end

  // Expected observation at busy cycle k of a burst with gap g.
  function automatic logic [8:0] exp_obs(int k, int g);
    int gp, per, f, p;
    logic [1:0] sym;
    logic sv;
    logic [3:0] fc;
    gp  = (g == 0) ? 1 : g;
    per = 3 + gp;
    f   = k / per;
    p   = k % per;
    if (p < 3) begin
      sym = (p == 1) ? 2'b00 : 2'b10;
      sv  = 1'b1;
      fc  = 4'(f);
    end else begin
      sym = 2'b11;
      sv  = 1'b0;
      fc  = 4'(f + 1);
    end
    return {sym, sv, 1'b1, 1'b0, fc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] n, input logic [2:0] g);
    start = 1'b1; repeat_n = n; gap = g;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 9'b11_000_0000) begin
      errors++; $display("FAIL reset_hold got=%b exp=%b", obs, 9'b11_000_0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== 9'b11_000_0000) begin
        errors++; $display("FAIL reset_idle c%0d got=%b exp=%b", i, obs, 9'b11_000_0000);
      end
    end
  endtask

  task automatic test_single();
    int h0, g0;
    h0 = det_hits; g0 = gap_hits;
    launch(4'd1, 3'd2);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== exp_obs(k, 2)) begin
        errors++; $display("FAIL single k%0d got=%b exp=%b", k, obs, exp_obs(k, 2));
      end
      tick();
    end
    checks++;
    if (obs !== 9'b11_001_0001) begin
      errors++; $display("FAIL single_done got=%b exp=%b", obs, 9'b11_001_0001);
    end
    tick();
    checks++;
    if (obs !== 9'b11_000_0001) begin
      errors++; $display("FAIL single_after got=%b exp=%b", obs, 9'b11_000_0001);
    end
    checks++;
    if (det_hits - h0 !== 1 || gap_hits != g0) begin
      errors++; $display("FAIL single_det got=%0d exp=1", det_hits - h0);
    end
  endtask

  task automatic test_multi();
    int h0, g0;
    h0 = det_hits; g0 = gap_hits;
    launch(4'd3, 3'd2);
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (obs !== exp_obs(k, 2)) begin
        errors++; $display("FAIL multi k%0d got=%b exp=%b", k, obs, exp_obs(k, 2));
      end
      // A start request mid-burst must not re-latch count or gap.
      if (k == 4) begin start = 1'b1; repeat_n = 4'd1; gap = 3'd0; end
      else start = 1'b0;
      tick();
    end
    checks++;
    if (obs !== 9'b11_001_0011) begin
      errors++; $display("FAIL multi_done got=%b exp=%b", obs, 9'b11_001_0011);
    end
    tick();
    checks++;
    if (obs !== 9'b11_000_0011) begin
      errors++; $display("FAIL multi_after got=%b exp=%b", obs, 9'b11_000_0011);
    end
    checks++;
    if (det_hits - h0 !== 3 || gap_hits != g0) begin
      errors++; $display("FAIL multi_det got=%0d/%0d exp=3/0", det_hits - h0, gap_hits - g0);
    end
  endtask

  task automatic test_gap0();
    int h0;
    h0 = det_hits;
    launch(4'd2, 3'd0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (obs !== exp_obs(k, 0)) begin
        errors++; $display("FAIL gap0 k%0d got=%b exp=%b", k, obs, exp_obs(k, 0));
      end
      tick();
    end
    checks++;
    if (obs !== 9'b11_001_0010) begin
      errors++; $display("FAIL gap0_done got=%b exp=%b", obs, 9'b11_001_0010);
    end
    tick();
    checks++;
    if (obs !== 9'b11_000_0010) begin
      errors++; $display("FAIL gap0_after got=%b exp=%b", obs, 9'b11_000_0010);
    end
    checks++;
    if (det_hits - h0 !== 2) begin
      errors++; $display("FAIL gap0_det got=%0d exp=2", det_hits - h0);
    end
  endtask

  task automatic test_abort();
    launch(4'd4, 3'd2);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (obs !== exp_obs(k, 2)) begin
        errors++; $display("FAIL abort_run k%0d got=%b exp=%b", k, obs, exp_obs(k, 2));
      end
      if (k < 6) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs !== 9'b11_000_0001) begin
      errors++; $display("FAIL abort_idle got=%b exp=%b", obs, 9'b11_000_0001);
    end
    tick();
    checks++;
    if (obs !== 9'b11_000_0001) begin
      errors++; $display("FAIL abort_hold got=%b exp=%b", obs, 9'b11_000_0001);
    end
    // abort beats start in IDLE
    abort = 1'b1;
    launch(4'd2, 3'd1);
    abort = 1'b0;
    checks++;
    if (obs !== 9'b11_000_0001) begin
      errors++; $display("FAIL abort_start got=%b exp=%b", obs, 9'b11_000_0001);
    end
  endtask

  task automatic test_rst_gap();
    launch(4'd3, 3'd2);
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (obs !== exp_obs(3, 2)) begin
      errors++; $display("FAIL rst_gap_pre got=%b exp=%b", obs, exp_obs(3, 2));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== 9'b11_000_0000) begin
      errors++; $display("FAIL rst_gap got=%b exp=%b", obs, 9'b11_000_0000);
    end
    tick();
    checks++;
    if (obs !== 9'b11_000_0000) begin
      errors++; $display("FAIL rst_gap_after got=%b exp=%b", obs, 9'b11_000_0000);
    end
  endtask

  task automatic test_zero();
    launch(4'd3, 3'd1);
    for (int k = 0; k < 3; k++) tick();
    launch_zero();
  endtask

  task automatic launch_zero();
    // let the running burst end: frames 2 and 3 remain after k=3
    for (int k = 0; k < 9; k++) tick();
    checks++;
    if (obs !== 9'b11_000_0011) begin
      errors++; $display("FAIL zero_pre got=%b exp=%b", obs, 9'b11_000_0011);
    end
    launch(4'd0, 3'd2);
    checks++;
    if (obs !== 9'b11_001_0000) begin
      errors++; $display("FAIL zero_done got=%b exp=%b", obs, 9'b11_001_0000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 9'b11_000_0000) begin
        errors++; $display("FAIL zero_idle c%0d got=%b exp=%b", i, obs, 9'b11_000_0000);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_multi();
    test_gap0();
    test_abort();
    test_rst_gap();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
